// File: rtl/aib_mac_chk_pkg.sv
// AIB MAC receive word-alignment checker: shared types and constants.
// Holds the checker state encoding and counter widths.
package aib_mac_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } wa_state_e;

    localparam int SEQ_W          = 16;
    localparam int ERR_CNT_W      = 4;
    localparam int WORD_CNT_W     = 16;
    localparam int LOCK_CNT_DEF   = 4;
    localparam int UNLOCK_CNT_DEF = 3;

endpackage

// File: rtl/aib_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count never wraps.
module aib_sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // count up until all ones, clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/aib_mac_rx_wa_chk.sv
// Word-alignment checker for the AIB MAC receive path.
// Locks onto a marker/sequence pattern and counts errors once locked.
module aib_mac_rx_wa_chk
    import aib_mac_chk_pkg::*;
#(
    parameter int DWIDTH     = 40,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic                  m_rd_clk,
    input  logic                  rd_rstn,
    input  logic                  rx_en,
    input  logic [2*DWIDTH-1:0]   data_out,
    input  logic                  chk_clr,
    output logic                  align_done,
    output logic                  wa_error,
    output logic [ERR_CNT_W-1:0]  wa_error_cnt,
    output logic [WORD_CNT_W-1:0] rx_word_cnt
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(UNLOCK_CNT + 1);

    wa_state_e        r_state;
    logic [SEQ_W-1:0] r_expected;
    logic [RUN_W-1:0] r_run;
    logic [BAD_W-1:0] r_bad;
    logic             r_align;
    logic             r_err;

    wa_state_e        w_state_nxt;
    logic [SEQ_W-1:0] w_exp_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [BAD_W-1:0] w_bad_nxt;
    logic             w_align_nxt;
    logic             w_err_nxt;
    logic             w_err_inc;
    logic             w_word_inc;

    logic [2*DWIDTH-1:0] w_other;
    logic [SEQ_W-1:0]    w_seq;
    logic                w_mark_ok;
    logic                w_good;

    assign w_seq = data_out[SEQ_W-1:0];

    // isolate every bit that must be zero in a well-formed word
    always_comb begin
        w_other              = data_out;
        w_other[2*DWIDTH-1]  = 1'b0;
        w_other[DWIDTH-1]    = 1'b0;
        w_other[SEQ_W-1:0]   = '0;
    end

    assign w_mark_ok = data_out[2*DWIDTH-1] & ~data_out[DWIDTH-1]
                     & (w_other == '0);
    assign w_good    = w_mark_ok & (w_seq == r_expected);

    // state and tracking registers
    always_ff @(posedge m_rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            r_state    <= ST_IDLE;
            r_expected <= '0;
            r_run      <= '0;
            r_bad      <= '0;
            r_align    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_expected <= w_exp_nxt;
            r_run      <= w_run_nxt;
            r_bad      <= w_bad_nxt;
            r_align    <= w_align_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // next-state: the IDLE edge already evaluates its word like SEARCH
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_expected;
        w_run_nxt   = r_run;
        w_bad_nxt   = r_bad;
        w_align_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_err_inc   = 1'b0;
        w_word_inc  = 1'b0;
        if (!rx_en) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
            w_bad_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_SEARCH: begin
                    w_state_nxt = ST_SEARCH;
                    if (w_mark_ok) begin
                        w_exp_nxt = w_seq + SEQ_W'(1);
                        if ((r_run != '0) && (w_seq == r_expected)) begin
                            w_run_nxt = r_run + RUN_W'(1);
                        end else begin
                            w_run_nxt = RUN_W'(1);
                        end
                        if (w_run_nxt == RUN_W'(LOCK_CNT)) begin
                            w_state_nxt = ST_LOCKED;
                            w_align_nxt = 1'b1;
                            w_bad_nxt   = '0;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    w_exp_nxt   = r_expected + SEQ_W'(1);
                    w_align_nxt = 1'b1;
                    if (w_good) begin
                        w_bad_nxt  = '0;
                        w_word_inc = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_err_inc = 1'b1;
                        w_bad_nxt = r_bad + BAD_W'(1);
                        if (w_bad_nxt == BAD_W'(UNLOCK_CNT)) begin
                            w_state_nxt = ST_SEARCH;
                            w_align_nxt = 1'b0;
                            w_run_nxt   = '0;
                            w_bad_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = '0;
                    w_bad_nxt   = '0;
                end
            endcase
        end
    end

    aib_sat_cnt #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk   (m_rd_clk),
        .rst_n (rd_rstn),
        .i_inc (w_err_inc),
        .i_clr (chk_clr),
        .o_cnt (wa_error_cnt)
    );

    aib_sat_cnt #(
        .W(WORD_CNT_W)
    ) u_word_cnt (
        .clk   (m_rd_clk),
        .rst_n (rd_rstn),
        .i_inc (w_word_inc),
        .i_clr (chk_clr),
        .o_cnt (rx_word_cnt)
    );

    assign align_done = r_align;
    assign wa_error   = r_err;

endmodule
